// File: rtl/ttt_game_core_param.sv
// NxN tic-tac-toe core: keypad move capture, board register, per-turn BCD
// countdown with forfeit on timeout, and win/draw detection.
module ttt_game_core_param #(
  parameter int unsigned N             = 3,
  parameter int unsigned WIN_LEN       = 3,
  parameter int unsigned TURN_SECS     = 15,
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               new_game,
  output logic [2*N*N-1:0]   board,
  output logic [1:0]         game_state,
  output logic               whos_turn,
  output logic [3:0]         time_tens,
  output logic [3:0]         time_ones,
  output logic [4:0]         move_count
);

  localparam int unsigned CELLS     = N * N;
  localparam int unsigned TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    TENS_INIT = 4'(TURN_SECS / 10);
  localparam logic [3:0]    ONES_INIT = 4'(TURN_SECS % 10);
  localparam logic [4:0]    CELLS_5   = 5'(CELLS);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  state_t          state;
  logic [TW-1:0]   tick;
  logic [1:0]      mark;
  logic            cell_free;
  logic            key_ok;
  logic            win;
  logic [2*N*N-1:0] board_next;

  assign mark = {whos_turn, ~whos_turn};

  always_comb begin
    cell_free  = 1'b0;
    board_next = board;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (key_code == 4'(i)) begin
        cell_free               = (board[2*i +: 2] == 2'b00);
        board_next[2*i +: 2]    = mark;
      end
    end
    key_ok = key_valid && ({1'b0, key_code} < CELLS_5) && cell_free;
  end

  // True when WIN_LEN cells starting at 'start', spaced by 'step', all hold m.
  function automatic logic run_at(input logic [2*N*N-1:0] b, input logic [1:0] m,
                                  input int unsigned start, input int unsigned step);
    logic all_m;
    all_m = 1'b1;
    for (int unsigned k = 0; k < WIN_LEN; k++) begin
      if (b[2*(start + k*step) +: 2] != m) all_m = 1'b0;
    end
    return all_m;
  endfunction

  // Scanning every run for the mover's mark is equivalent to scanning runs
  // through the last cell: any earlier complete run would already have ended the game.
  always_comb begin
    win = 1'b0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (c + WIN_LEN <= N && run_at(board, mark, r*N + c, 1)) win = 1'b1;
        if (r + WIN_LEN <= N && run_at(board, mark, r*N + c, N)) win = 1'b1;
        if (r + WIN_LEN <= N && c + WIN_LEN <= N && run_at(board, mark, r*N + c, N + 1))
          win = 1'b1;
        if (r + WIN_LEN <= N && c + 1 >= WIN_LEN && run_at(board, mark, r*N + c, N - 1))
          win = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= PLAY;
      board      <= '0;
      game_state <= 2'b00;
      whos_turn  <= 1'b0;
      move_count <= '0;
      time_tens  <= TENS_INIT;
      time_ones  <= ONES_INIT;
      tick       <= '0;
    end else if (new_game) begin
      state      <= PLAY;
      board      <= '0;
      game_state <= 2'b00;
      whos_turn  <= 1'b0;
      move_count <= '0;
      time_tens  <= TENS_INIT;
      time_ones  <= ONES_INIT;
      tick       <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (key_ok) begin
            board      <= board_next;
            move_count <= move_count + 5'd1;
            state      <= CHECK;
          end else if (tick == TICK_MAX) begin
            tick <= '0;
            if (time_tens == 4'd0 && time_ones == 4'd0) begin
              whos_turn <= ~whos_turn;
              time_tens <= TENS_INIT;
              time_ones <= ONES_INIT;
            end else if (time_ones == 4'd0) begin
              time_ones <= 4'd9;
              time_tens <= time_tens - 4'd1;
            end else begin
              time_ones <= time_ones - 4'd1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        CHECK: begin
          if (win) begin
            game_state <= mark;
            state      <= OVER;
          end else if (move_count == CELLS_5) begin
            game_state <= 2'b11;
            state      <= OVER;
          end else begin
            whos_turn <= ~whos_turn;
            time_tens <= TENS_INIT;
            time_ones <= ONES_INIT;
            tick      <= '0;
            state     <= PLAY;
          end
        end
        default: state <= OVER;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_core_param.sv
// Directed bench for ttt_game_core_param: a 3x3 instance for move, win, draw,
// timeout and collision cases, and a 4x4/WIN_LEN=3 instance for anti-diagonals and async reset.
module tb_ttt_game_core_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        rst_a, kv_a, ng_a;
  logic [3:0]  kc_a;
  logic [17:0] board_a;
  logic [1:0]  gs_a;
  logic        turn_a;
  logic [3:0]  tens_a, ones_a;
  logic [4:0]  mc_a;

  logic        rst_b, kv_b, ng_b;
  logic [3:0]  kc_b;
  logic [31:0] board_b;
  logic [1:0]  gs_b;
  logic        turn_b;
  logic [3:0]  tens_b, ones_b;
  logic [4:0]  mc_b;

  ttt_game_core_param #(.N(3), .WIN_LEN(3), .TURN_SECS(15), .TICKS_PER_SEC(10)) dut_a (
    .clock(clock), .rst(rst_a), .key_valid(kv_a), .key_code(kc_a), .new_game(ng_a),
    .board(board_a), .game_state(gs_a), .whos_turn(turn_a),
    .time_tens(tens_a), .time_ones(ones_a), .move_count(mc_a));

  ttt_game_core_param #(.N(4), .WIN_LEN(3), .TURN_SECS(15), .TICKS_PER_SEC(10)) dut_b (
    .clock(clock), .rst(rst_b), .key_valid(kv_b), .key_code(kc_b), .new_game(ng_b),
    .board(board_b), .game_state(gs_b), .whos_turn(turn_b),
    .time_tens(tens_b), .time_ones(ones_b), .move_count(mc_b));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_a(input logic [3:0] k);
    @(negedge clock); kv_a = 1'b1; kc_a = k;
    @(negedge clock); kv_a = 1'b0;
  endtask

  task automatic press_b(input logic [3:0] k);
    @(negedge clock); kv_b = 1'b1; kc_b = k;
    @(negedge clock); kv_b = 1'b0;
  endtask

  task automatic restart_a();
    @(negedge clock); ng_a = 1'b1;
    @(negedge clock); ng_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; kv_a = 1'b0; kc_a = 4'd0; ng_a = 1'b0;
    rst_b = 1'b0; kv_b = 1'b0; kc_b = 4'd0; ng_b = 1'b0;
    repeat (3) @(negedge clock);

    // reset values
    check_val("rst_board", 32'(board_a), 32'h0);
    check_val("rst_state", 32'(gs_a), 32'h0);
    check_val("rst_turn", 32'(turn_a), 32'h0);
    check_val("rst_tens", 32'(tens_a), 32'd1);
    check_val("rst_ones", 32'(ones_a), 32'd5);
    check_val("rst_count", 32'(mc_a), 32'd0);
    rst_a = 1'b1;

    // occupied and out-of-range keys
    press_a(4'd4);
    check_val("o_cell4", 32'(board_a[9:8]), 32'h1);
    check_val("o_count", 32'(mc_a), 32'd1);
    check_val("turn_in_check", 32'(turn_a), 32'h0);
    @(negedge clock);
    check_val("turn_to_x", 32'(turn_a), 32'h1);
    press_a(4'd4);
    check_val("occ_cell4", 32'(board_a[9:8]), 32'h1);
    check_val("occ_turn", 32'(turn_a), 32'h1);
    check_val("occ_count", 32'(mc_a), 32'd1);
    press_a(4'd12);
    check_val("oor_board", 32'(board_a), 32'h100);
    check_val("oor_count", 32'(mc_a), 32'd1);
    check_val("oor_turn", 32'(turn_a), 32'h1);

    // O wins on the top row
    restart_a();
    press_a(4'd0); press_a(4'd3); press_a(4'd1); press_a(4'd4); press_a(4'd2);
    check_val("win_row_bits", 32'(board_a[5:0]), 32'h15);
    check_val("win_count", 32'(mc_a), 32'd5);
    check_val("win_pending", 32'(gs_a), 32'h0);
    @(negedge clock);
    check_val("win_o", 32'(gs_a), 32'h1);
    check_val("win_turn", 32'(turn_a), 32'h0);
    press_a(4'd5);
    repeat (30) @(negedge clock);
    check_val("over_count", 32'(mc_a), 32'd5);
    check_val("over_state", 32'(gs_a), 32'h1);
    check_val("over_tens", 32'(tens_a), 32'd1);
    check_val("over_ones", 32'(ones_a), 32'd5);

    // draw
    restart_a();
    press_a(4'd0); press_a(4'd1); press_a(4'd2); press_a(4'd4); press_a(4'd3);
    press_a(4'd5); press_a(4'd7); press_a(4'd6); press_a(4'd8);
    @(negedge clock);
    check_val("draw_state", 32'(gs_a), 32'h3);
    check_val("draw_board", 32'(board_a), 32'(18'b01_01_10_10_10_01_01_10_01));
    check_val("draw_count", 32'(mc_a), 32'd9);
    press_a(4'd0);
    check_val("draw_hold", 32'(mc_a), 32'd9);
    restart_a();
    check_val("ng_board", 32'(board_a), 32'h0);
    check_val("ng_state", 32'(gs_a), 32'h0);
    check_val("ng_turn", 32'(turn_a), 32'h0);
    check_val("ng_tens", 32'(tens_a), 32'd1);
    check_val("ng_ones", 32'(ones_a), 32'd5);

    // idle countdown and forfeit
    repeat (10) @(negedge clock);
    check_val("t10_tens", 32'(tens_a), 32'd1);
    check_val("t10_ones", 32'(ones_a), 32'd4);
    repeat (60) @(negedge clock);
    check_val("t70_tens", 32'(tens_a), 32'd0);
    check_val("t70_ones", 32'(ones_a), 32'd8);
    repeat (80) @(negedge clock);
    check_val("t150_digits", 32'({tens_a, ones_a}), 32'h00);
    repeat (9) @(negedge clock);
    check_val("t159_digits", 32'({tens_a, ones_a}), 32'h00);
    check_val("t159_turn", 32'(turn_a), 32'h0);
    @(negedge clock);
    check_val("t160_turn", 32'(turn_a), 32'h1);
    check_val("t160_digits", 32'({tens_a, ones_a}), 32'h15);
    check_val("t160_board", 32'(board_a), 32'h0);
    check_val("t160_count", 32'(mc_a), 32'd0);

    // move in the same cycle as the timeout
    restart_a();
    repeat (159) @(negedge clock);
    kv_a = 1'b1; kc_a = 4'd4;
    @(negedge clock); kv_a = 1'b0;
    check_val("col_cell4", 32'(board_a[9:8]), 32'h1);
    check_val("col_turn_check", 32'(turn_a), 32'h0);
    check_val("col_digits_frozen", 32'({tens_a, ones_a}), 32'h00);
    @(negedge clock);
    check_val("col_turn", 32'(turn_a), 32'h1);
    check_val("col_digits", 32'({tens_a, ones_a}), 32'h15);
    @(negedge clock);
    check_val("col_turn_once", 32'(turn_a), 32'h1);
    check_val("col_count", 32'(mc_a), 32'd1);

    // 4x4, X completes anti-diagonal 3,6,9
    rst_b = 1'b1;
    press_b(4'd0); press_b(4'd3); press_b(4'd5); press_b(4'd6); press_b(4'd15); press_b(4'd9);
    @(negedge clock);
    check_val("b_win_x", 32'(gs_b), 32'h2);
    check_val("b_cells", 32'({board_b[19:18], board_b[13:12], board_b[7:6], board_b[1:0]}), 32'hA9);
    check_val("b_count", 32'(mc_b), 32'd6);
    check_val("b_turn", 32'(turn_b), 32'h1);
    press_b(4'd15);
    check_val("b_over_count", 32'(mc_b), 32'd6);

    // async reset during CHECK
    rst_b = 1'b0;
    @(negedge clock); rst_b = 1'b1;
    press_b(4'd15);
    check_val("b_pre_rst_count", 32'(mc_b), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check_val("b_arst_board", board_b, 32'h0);
    check_val("b_arst_state", 32'(gs_b), 32'h0);
    check_val("b_arst_turn", 32'(turn_b), 32'h0);
    check_val("b_arst_count", 32'(mc_b), 32'd0);
    check_val("b_arst_digits", 32'({tens_b, ones_b}), 32'h15);
    @(negedge clock); rst_b = 1'b1;
    @(negedge clock);
    check_val("b_after_state", 32'(gs_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
